// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RISC-V core definitions used by the fetch stage:
//                datapath width, canonical NOP encoding, fetch FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Default datapath / address width
    localparam int XLEN = 32;

    // addi x0, x0, 0 - canonical NOP loaded into IF/ID on reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch state machine encoding
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter register with next-pc selection
//                (redirect / sequential +4 / hold) and bad-address detection
//                for both the current pc and an incoming redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            pc_bad,
    output logic            target_bad
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Next pc: a redirect always wins; otherwise step by one word or hold
    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = redirect_target;
        end else if (advance) begin
            w_pc_next = r_pc + XLEN'(4);
        end
    end

    // PC register, reloaded with the reset vector on async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Instruction space is word aligned and confined to the lower half
    assign pc_bad     = (r_pc[1:0] != 2'b00) || r_pc[XLEN-1];
    assign target_bad = (redirect_target[1:0] != 2'b00) || redirect_target[XLEN-1];
    assign pc         = r_pc;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : RISC-V fetch stage. Drives the instruction memory address
//                from the pc, captures the returned word into the IF/ID
//                register (valid/ready to decode), handles redirects and
//                halts in FAULT on misaligned or out-of-range fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int               XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instruction,
    output logic            fetch_fault
);

    fetch_state_t    r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_instruction;

    logic [XLEN-1:0] w_pc;
    logic            w_pc_bad;
    logic            w_target_bad;
    logic            w_slot_free;
    logic            w_advance;

    // IF/ID can take a new word when empty or when decode drains it now
    assign w_slot_free = !r_out_valid || out_ready;

    // Sequential step only when a capture actually happens this cycle
    assign w_advance = !redirect_valid && (r_state == RUN) && !w_pc_bad && w_slot_free;

    fetch_pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (w_advance),
        .pc              (w_pc),
        .pc_bad          (w_pc_bad),
        .target_bad      (w_target_bad)
    );

    // Fetch FSM and IF/ID register, evaluated in strict priority order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= RUN;
            r_out_valid       <= 1'b0;
            r_out_pc          <= '0;
            r_out_instruction <= XLEN'(NOP_INSTR);
        end else if (redirect_valid) begin
            // Flush regardless of backpressure; a bad target faults at once
            r_out_valid <= 1'b0;
            r_state     <= w_target_bad ? FAULT : RUN;
        end else if (r_state == FAULT) begin
            // Let decode drain whatever is left, capture nothing new
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_pc_bad) begin
            // Halt on the bad pc; an already-held word may still drain
            r_state <= FAULT;
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_slot_free) begin
            r_out_valid       <= 1'b1;
            r_out_pc          <= w_pc;
            r_out_instruction <= imem_instruction;
        end
    end

    assign imem_addr       = w_pc;
    assign out_valid       = r_out_valid;
    assign out_pc          = r_out_pc;
    assign out_instruction = r_out_instruction;
    assign fetch_fault     = (r_state == FAULT);

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch: directed
//                scenarios followed by randomized ready/redirect traffic,
//                compared each cycle against a behavioural fetch model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        fetch_fault;

    logic [31:0] salt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_valid;
    logic [31:0] m_opc;
    logic [31:0] m_oinstr;

    always #5 clk = ~clk;

    // Memory: each word is its own address XOR a per-phase salt
    assign imem_instruction = imem_addr ^ salt;

    instruction_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .fetch_fault      (fetch_fault)
    );

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h8000_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_fault  = 1'b0;
        m_valid  = 1'b0;
        m_opc    = 32'h0;
        m_oinstr = NOP;
    endtask

    // One clock of the fetch rules, using the inputs present before the edge
    task automatic model_step();
        if (redirect_valid) begin
            m_valid = 1'b0;
            m_pc    = redirect_target;
            m_fault = is_bad(redirect_target);
        end else if (m_fault) begin
            if (out_ready) m_valid = 1'b0;
        end else if (is_bad(m_pc)) begin
            m_fault = 1'b1;
            if (out_ready) m_valid = 1'b0;
        end else if (!m_valid || out_ready) begin
            m_valid  = 1'b1;
            m_opc    = m_pc;
            m_oinstr = m_pc ^ salt;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    task automatic check_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_valid) begin
            chk("out_pc", out_pc, m_opc);
            chk("out_instruction", out_instruction, m_oinstr);
        end
    endtask

    // Advance one clock: model sees pre-edge inputs, outputs sampled #1 after
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b0;
        salt            = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instruction", out_instruction, NOP);
        chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Streaming 0,4,8
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stream_pc", out_pc, 32'(i * 4));
            chk("stream_instr", out_instruction, 32'(i * 4));
            chk("stream_valid", {31'b0, out_valid}, 32'h1);
        end

        // Backpressure at out_pc=8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", out_pc, 32'h8);
            chk("stall_addr", imem_addr, 32'hC);
        end
        out_ready = 1'b1;
        cycle();
        chk("release_pc", out_pc, 32'hC);
        cycle();
        chk("release_next_pc", out_pc, 32'h10);

        // Redirect under backpressure flushes IF/ID
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        cycle();
        chk("redir_flush_valid", {31'b0, out_valid}, 32'h0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        cycle();
        chk("redir_target_pc", out_pc, 32'h100);

        // Misaligned redirect faults until a good redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        cycle();
        chk("misalign_fault", {31'b0, fetch_fault}, 32'h1);
        redirect_valid = 1'b0;
        repeat (3) cycle();
        chk("fault_held", {31'b0, fetch_fault}, 32'h1);
        chk("fault_no_valid", {31'b0, out_valid}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        cycle();
        chk("fault_cleared", {31'b0, fetch_fault}, 32'h0);
        redirect_valid = 1'b0;
        cycle();
        chk("recover_pc", out_pc, 32'h200);

        // Run off the top of instruction space
        redirect_valid  = 1'b1;
        redirect_target = 32'h7FFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("top_pc0", out_pc, 32'h7FFF_FFF8);
        cycle();
        chk("top_pc1", out_pc, 32'h7FFF_FFFC);
        cycle();
        chk("top_fault", {31'b0, fetch_fault}, 32'h1);
        chk("top_addr", imem_addr, 32'h8000_0000);
        chk("top_no_valid", {31'b0, out_valid}, 32'h0);

        // Async reset in the middle of a stall at 0x40
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("pre_rst_pc", out_pc, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_instr", out_instruction, NOP);
        chk("async_rst_addr", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("restart_pc", out_pc, 32'h0);

        // Randomized ready/redirect traffic
        salt = $urandom;
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 4))
                0:       redirect_target = $urandom & 32'h7FFF_FFFC;
                1:       redirect_target = 32'h7FFF_FFF0;
                2:       redirect_target = ($urandom & 32'h0000_0FFC) | 32'(1 + $urandom_range(0, 2));
                3:       redirect_target = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
                default: redirect_target = $urandom & 32'h0000_0FFC;
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch
`default_nettype wire
